// File: rtl/nfca_tx_miller_if.sv
// Bit-stream interface between nfca_tx_frame, the Modified Miller encoder
// and the RF front-end.
//   tx_req     : encoder -> frame builder, one-cycle next-bit request
//   tx_en      : frame builder -> encoder, bit valid
//   tx_bit     : frame builder -> encoder, bit value
//   carrier_on : encoder -> RF front-end, 1 = carrier, 0 = pause
//   tx_active  : encoder -> system, current symbol carries a valid bit
// modport master : encoder side
// modport slave  : frame builder / front-end side
interface nfca_tx_miller_if;
    logic tx_req;
    logic tx_en;
    logic tx_bit;
    logic carrier_on;
    logic tx_active;

    modport master (
        output tx_req,
        output carrier_on,
        output tx_active,
        input  tx_en,
        input  tx_bit
    );

    modport slave (
        input  tx_req,
        input  carrier_on,
        input  tx_active,
        output tx_en,
        output tx_bit
    );
endinterface

// File: rtl/nfca_tx_miller.sv
// ISO14443-A PCD->PICC Modified Miller bit encoder.
// Paces nfca_tx_frame with one tx_req pulse per bit period and converts its
// tx_en/tx_bit stream into X/Y/Z symbols on carrier_on (1 = carrier, 0 = pause).
// Ports:
//   clk   : system clock (fc)
//   rstn  : asynchronous active-low reset
//   bus   : nfca_tx_miller_if.master (tx_req, tx_en, tx_bit, carrier_on, tx_active)
// Optional feature: define NFCA_TX_GUARD_EN to suppress tx_req for GUARD_BITS
// bit periods after each frame. Undefined: tx_req pulses every period.
module nfca_tx_miller #(
    parameter int unsigned CLK_PER_BIT = 128,
    parameter int unsigned PAUSE_LEN   = 40,
    parameter int unsigned REQ_LEAD    = 4,
    parameter int unsigned GUARD_BITS  = 8
) (
    input  logic             clk,
    input  logic             rstn,
    nfca_tx_miller_if.master bus
);

    localparam int unsigned CNT_W = $clog2(CLK_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [CNT_W-1:0] REQ_CNT  = CNT_W'(CLK_PER_BIT - REQ_LEAD);
    localparam logic [CNT_W-1:0] X_START  = CNT_W'(CLK_PER_BIT / 2);
    localparam logic [CNT_W-1:0] X_END    = CNT_W'(CLK_PER_BIT / 2 + PAUSE_LEN);
    localparam logic [CNT_W-1:0] Z_END    = CNT_W'(PAUSE_LEN);

    typedef enum logic [1:0] {
        SYM_Y = 2'd0,
        SYM_X = 2'd1,
        SYM_Z = 2'd2
    } sym_e;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    sym_e             sym_q, sym_d;
    logic             prev_x_q, prev_x_d;
    logic             active_q, active_d;
    logic             carrier_q, carrier_d;
    logic             req_q, req_d;
    logic             sample_c;
    logic             pause_c;

`ifdef NFCA_TX_GUARD_EN
    localparam int unsigned GUARD_W = $clog2(GUARD_BITS + 1);

    logic [GUARD_W-1:0] guard_q, guard_d;
`endif

    // State registers; reset leaves the carrier on and no request pending
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q     <= '0;
            sym_q     <= SYM_Y;
            prev_x_q  <= 1'b0;
            active_q  <= 1'b0;
            carrier_q <= 1'b1;
            req_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            sym_q     <= sym_d;
            prev_x_q  <= prev_x_d;
            active_q  <= active_d;
            carrier_q <= carrier_d;
            req_q     <= req_d;
        end
    end

`ifdef NFCA_TX_GUARD_EN
    // Post-frame guard counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            guard_q <= '0;
        end else begin
            guard_q <= guard_d;
        end
    end
`endif

    // Next-state: period counter, symbol selection and registered outputs.
    // Outputs are computed from the next cnt/symbol so they line up with cnt_q.
    always_comb begin
        cnt_d    = cnt_q + CNT_W'(1);
        sym_d    = sym_q;
        prev_x_d = prev_x_q;
        active_d = active_q;
        sample_c = (cnt_q == CNT_LAST);
        pause_c  = 1'b0;

        if (sample_c) begin
            cnt_d = '0;
            if (!bus.tx_en) begin
                sym_d    = SYM_Y;
                prev_x_d = 1'b0;
                active_d = 1'b0;
            end else if (bus.tx_bit) begin
                sym_d    = SYM_X;
                prev_x_d = 1'b1;
                active_d = 1'b1;
            end else begin
                // A 0 right after a 1 is Y so two pauses never come too close
                sym_d    = prev_x_q ? SYM_Y : SYM_Z;
                prev_x_d = 1'b0;
                active_d = 1'b1;
            end
        end

        case (sym_d)
            SYM_X:   pause_c = (cnt_d >= X_START) && (cnt_d < X_END);
            SYM_Z:   pause_c = (cnt_d < Z_END);
            default: pause_c = 1'b0;
        endcase

        carrier_d = !pause_c;
        req_d     = (cnt_d == REQ_CNT);
    end

`ifdef NFCA_TX_GUARD_EN
    // Load on the first idle period after a frame, count down once per period
    always_comb begin
        guard_d = guard_q;
        if (sample_c) begin
            if (!bus.tx_en && active_q) begin
                guard_d = GUARD_W'(GUARD_BITS);
            end else if (guard_q != '0) begin
                guard_d = guard_q - GUARD_W'(1);
            end
        end
    end

    assign bus.tx_req = req_q && (guard_q == '0);
`else
    assign bus.tx_req = req_q;
`endif

    assign bus.carrier_on = carrier_q;
    assign bus.tx_active  = active_q;

endmodule

// File: tb/tb_nfca_tx_miller.sv
// Bench for nfca_tx_miller: acts as the frame builder, feeds a table of bits
// (one per tx_req), queues the expected symbol for the following period and
// checks carrier shape, tx_active and tx_req timing over every period.
`timescale 1ns/1ps
module tb_nfca_tx_miller;

    localparam int unsigned CPB    = 128;
    localparam int unsigned PL     = 40;
    localparam int unsigned RL     = 4;
    localparam int unsigned GB     = 8;
    localparam int          REQ_AT = int'(CPB - RL);

`ifdef NFCA_TX_GUARD_EN
    localparam logic GUARD = 1'b1;
`else
    localparam logic GUARD = 1'b0;
`endif

    typedef enum logic [1:0] {SY, SX, SZ} sym_t;

    typedef struct {
        logic en;
        logic bt;
        sym_t sym;   // symbol selected for the next period
        logic act;   // tx_active during that period
        logic req;   // tx_req expected during that period
        logic tag;   // period belongs to the REQA frame
    } vec_t;

    logic clk = 1'b0;
    logic rstn;

    nfca_tx_miller_if bus();

    nfca_tx_miller #(
        .CLK_PER_BIT (CPB),
        .PAUSE_LEN   (PL),
        .REQ_LEAD    (RL),
        .GUARD_BITS  (GB)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    vec_t vecs[$];
    vec_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   vi = 0;
    int   reqa_falls = 0;
    int   reqa_act = 0;
    logic prev_car = 1'b1;

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic void add(input logic en, input logic bt, input sym_t s,
                                input logic act, input logic req, input logic tag);
        vec_t v;
        v.en = en; v.bt = bt; v.sym = s; v.act = act; v.req = req; v.tag = tag;
        vecs.push_back(v);
    endfunction

    // Frame end: GB idle periods (no tx_req when the guard is built in), then one normal idle
    function automatic void add_tail(input logic tag);
        add(1'b0, 1'b0, SY, 1'b0, !GUARD, tag);
        for (int i = 1; i < int'(GB); i++) add(1'b0, 1'b0, SY, 1'b0, !GUARD, 1'b0);
        add(1'b0, 1'b0, SY, 1'b0, 1'b1, 1'b0);
    endfunction

    function automatic vec_t idle_vec();
        vec_t v;
        v.en = 1'b0; v.bt = 1'b0; v.sym = SY; v.act = 1'b0; v.req = 1'b1; v.tag = 1'b0;
        return v;
    endfunction

    function automatic logic exp_car(input sym_t s, input int c);
        case (s)
            SX:      return !((c >= int'(CPB / 2)) && (c < int'(CPB / 2 + PL)));
            SZ:      return !(c < int'(PL));
            default: return 1'b1;
        endcase
    endfunction

    // One bit period starting at cnt==0 (called on a negedge); stops after stop_at cycles
    task automatic run_period(input int stop_at);
        vec_t e;
        vec_t v;
        int   car_bad = 0;
        int   first_bad = -1;
        int   act_bad = 0;
        int   req_n = 0;
        int   req_pos = -1;
        int   pf = 0;
        int   act_mid = 0;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 0, 1);
            e = idle_vec();
        end else begin
            e = sb.pop_front();
        end
        for (int c = 0; c < stop_at; c++) begin
            if (bus.carrier_on !== exp_car(e.sym, c)) begin
                car_bad++;
                if (first_bad < 0) first_bad = c;
            end
            if (bus.tx_active !== e.act) act_bad++;
            if (c == int'(CPB / 2)) act_mid = (bus.tx_active === 1'b1) ? 1 : 0;
            if (bus.tx_req === 1'b1) begin
                req_n++;
                if (req_pos < 0) req_pos = c;
            end else if (bus.tx_req !== 1'b0) begin
                req_n += 100;
            end
            if (prev_car === 1'b1 && bus.carrier_on === 1'b0) pf++;
            prev_car = bus.carrier_on;
            // Frame builder registers the bit just after tx_req; earlier values are noise
            if (c == REQ_AT + 1) begin
                v = (vi < vecs.size()) ? vecs[vi] : idle_vec();
                vi++;
                bus.tx_en  = v.en;
                bus.tx_bit = v.bt;
                sb.push_back(v);
            end else if (c <= REQ_AT) begin
                bus.tx_en  = 1'($urandom);
                bus.tx_bit = 1'($urandom);
            end
            @(negedge clk);
        end
        check($sformatf("carrier_shape sym=%0d first_bad_cnt=%0d bad_cycles", e.sym, first_bad),
              car_bad, 0);
        check($sformatf("tx_active sym=%0d bad_cycles", e.sym), act_bad, 0);
        if (stop_at == int'(CPB)) begin
            check("tx_req_count", req_n, e.req ? 1 : 0);
            check("tx_req_cnt_pos", req_pos, e.req ? REQ_AT : -1);
        end
        if (e.tag) begin
            reqa_falls += pf;
            reqa_act   += act_mid;
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int split;
        bus.tx_en  = 1'b0;
        bus.tx_bit = 1'b0;
        rstn       = 1'b0;

        // Idle (~1000 cycles)
        for (int i = 0; i < 8; i++) add(1'b0, 1'b0, SY, 1'b0, 1'b1, 1'b0);
        // Lone 1 after idle, lone 0 after idle
        add(1'b1, 1'b1, SX, 1'b1, 1'b1, 1'b0); add_tail(1'b0);
        add(1'b1, 1'b0, SZ, 1'b1, 1'b1, 1'b0); add_tail(1'b0);
        // REQA 0x26: S, 0 1 1 0 0 1 0 (LSB first), E
        add(1'b1, 1'b0, SZ, 1'b1, 1'b1, 1'b1);
        add(1'b1, 1'b0, SZ, 1'b1, 1'b1, 1'b1);
        add(1'b1, 1'b1, SX, 1'b1, 1'b1, 1'b1);
        add(1'b1, 1'b1, SX, 1'b1, 1'b1, 1'b1);
        add(1'b1, 1'b0, SY, 1'b1, 1'b1, 1'b1);
        add(1'b1, 1'b0, SZ, 1'b1, 1'b1, 1'b1);
        add(1'b1, 1'b1, SX, 1'b1, 1'b1, 1'b1);
        add(1'b1, 1'b0, SY, 1'b1, 1'b1, 1'b1);
        add(1'b1, 1'b0, SZ, 1'b1, 1'b1, 1'b1);
        add_tail(1'b1);
        // 1,0,0,1,1 -> X Y Z X X
        add(1'b1, 1'b1, SX, 1'b1, 1'b1, 1'b0);
        add(1'b1, 1'b0, SY, 1'b1, 1'b1, 1'b0);
        add(1'b1, 1'b0, SZ, 1'b1, 1'b1, 1'b0);
        add(1'b1, 1'b1, SX, 1'b1, 1'b1, 1'b0);
        add(1'b1, 1'b1, SX, 1'b1, 1'b1, 1'b0);
        add_tail(1'b0);
        // X period that gets interrupted by reset
        add(1'b1, 1'b1, SX, 1'b1, 1'b1, 1'b0);
        split = vecs.size();
        // After the reset
        add(1'b0, 1'b0, SY, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b0, SZ, 1'b1, 1'b1, 1'b0);
        add_tail(1'b0);

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_tx_req", int'(bus.tx_req), 0);
        check("rst_carrier_on", int'(bus.carrier_on), 1);
        check("rst_tx_active", int'(bus.tx_active), 0);
        rstn = 1'b1;
        sb.push_back(idle_vec());

        while (vi < split) run_period(int'(CPB));

        // Reset in the middle of an X pause (cnt==70)
        run_period(70);
        check("x_pause_before_reset", int'(bus.carrier_on), 0);
        #1 rstn = 1'b0;
        #1;
        check("async_rst_carrier_on", int'(bus.carrier_on), 1);
        check("async_rst_tx_req", int'(bus.tx_req), 0);
        check("async_rst_tx_active", int'(bus.tx_active), 0);
        bus.tx_en  = 1'b0;
        bus.tx_bit = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        sb.delete();
        sb.push_back(idle_vec());
        prev_car = 1'b1;

        while (vi < vecs.size()) run_period(int'(CPB));

        check("reqa_pauses", reqa_falls, 7);
        check("reqa_active_periods", reqa_act, 9);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
